// File: rtl/nano_mem_loader_pkg.sv
// Shared definitions for the boot-loader memory: default geometry and loader FSM states.
package nano_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    LOAD_HI,
    LOAD_LO,
    RELEASE,
    RUN
  } ld_state_e;

endpackage

// File: rtl/nano_mem_loader_if.sv
// CPU bus and byte-loader handshake bundled for the loader memory.
interface nano_mem_loader_if #(
  parameter int unsigned ADDR_W = nano_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = nano_pkg::DATA_W_DEF
);

  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_dataW;
  logic              cpu_ce;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_dataR;
  logic              cpu_rst;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic              ld_start;
  logic              ld_ready;
  logic [ADDR_W:0]   ld_words;

  modport master (
    output cpu_address, cpu_dataW, cpu_ce, cpu_we,
    output ld_valid, ld_byte, ld_last, ld_start,
    input  cpu_dataR, cpu_rst, ld_ready, ld_words
  );

  modport slave (
    input  cpu_address, cpu_dataW, cpu_ce, cpu_we,
    input  ld_valid, ld_byte, ld_last, ld_start,
    output cpu_dataR, cpu_rst, ld_ready, ld_words
  );

endinterface

// File: rtl/nano_mem_loader_ram.sv
// Program memory: one write port muxed between loader and CPU by FSM state, async read.
module nano_ram
  import nano_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              ck,
  input  ld_state_e         state_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // CPU owns the port only in RUN, so loader and CPU writes can never collide.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state_i == RUN) begin
      wr_en   = cpu_we_i;
      wr_addr = cpu_addr_i;
      wr_data = cpu_data_i;
    end else begin
      wr_en   = ld_we_i;
      wr_addr = ld_addr_i;
      wr_data = ld_data_i;
    end
  end

  always_ff @(posedge ck) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nano_mem_loader.sv
// Byte-serial program loader: assembles hi/lo bytes into words, holds the CPU in reset until loaded.
module nano_mem_loader
  import nano_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input logic               ck,
  input logic               rst,
  nano_mem_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0]   WORDS_ONE = 1;
  localparam logic [ADDR_W:0]   WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  ld_state_e         state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   words_q;
  logic [7:0]        hi_q;
  logic              cpu_rst_q;
  logic              ready_q;
  logic              xfer;
  logic              ld_we;
  logic [DATA_W-1:0] rdata;

  assign xfer  = bus.ld_valid & ready_q;
  assign ld_we = (state_q == LOAD_LO) & xfer;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD_HI;
      ptr_q     <= '0;
      words_q   <= '0;
      hi_q      <= '0;
      cpu_rst_q <= 1'b1;
      ready_q   <= 1'b1;
    end else begin
      case (state_q)
        LOAD_HI: begin
          if (xfer) begin
            hi_q    <= bus.ld_byte;
            state_q <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (xfer) begin
            ptr_q <= ptr_q + PTR_ONE;
            if (words_q != WORDS_MAX) words_q <= words_q + WORDS_ONE;
            // A full memory ends the load even without ld_last.
            if (bus.ld_last || (ptr_q == '1)) begin
              state_q <= RELEASE;
              ready_q <= 1'b0;
            end else begin
              state_q <= LOAD_HI;
            end
          end
        end
        RELEASE: begin
          state_q   <= RUN;
          cpu_rst_q <= 1'b0;
        end
        RUN: begin
          if (bus.ld_start) begin
            state_q   <= LOAD_HI;
            ptr_q     <= '0;
            words_q   <= '0;
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b1;
          end
        end
        default: state_q <= LOAD_HI;
      endcase
    end
  end

  nano_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .ck         (ck),
    .state_i    (state_q),
    .cpu_we_i   (bus.cpu_ce & bus.cpu_we),
    .cpu_addr_i (bus.cpu_address),
    .cpu_data_i (bus.cpu_dataW),
    .ld_we_i    (ld_we),
    .ld_addr_i  (ptr_q),
    .ld_data_i  ({hi_q, bus.ld_byte}),
    .raddr_i    (bus.cpu_address),
    .rdata_o    (rdata)
  );

  assign bus.cpu_dataR = rdata;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.ld_ready  = ready_q;
  assign bus.ld_words  = words_q;

endmodule
